// File: rtl/dev_timer.sv
// Programmable down-counter timer with CTRL/PRESET/COUNT registers and a level IRQ.
// Optional macro DEV_TIMER_IRQ_EN enables irq_pend, the IM bit and the IRQ output.
`ifndef DEV_ADDR_WD
`define DEV_ADDR_WD 32
`endif

module dev_timer (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [`DEV_ADDR_WD-1:0] Addr,
    input  logic                    WE,
    input  logic [31:0]             WD,
    output logic [31:0]             RD,
    output logic                    IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } stateT;

    stateT       state;
    logic        en;
    logic [1:0]  mode;
    logic [31:0] preset;
    logic [31:0] count;
    logic        ctrlWrite;
    logic        presetWrite;
    logic        imBit;
    logic        unusedAddr;

    assign ctrlWrite   = WE && (Addr[3:2] == 2'd0);
    assign presetWrite = WE && (Addr[3:2] == 2'd1);
    assign unusedAddr  = ^{Addr[`DEV_ADDR_WD-1:4], Addr[1:0]};

`ifdef DEV_TIMER_IRQ_EN
    logic im;
    logic irqPend;

    assign imBit = im;
    assign IRQ   = irqPend & im;
`else
    assign imBit = 1'b0;
    assign IRQ   = 1'b0;
`endif

    // A CTRL write is applied after the FSM update so it overrides any
    // same-edge internal EN clear or irq_pend set.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            en     <= 1'b0;
            mode   <= 2'd0;
            preset <= 32'd0;
            count  <= 32'd0;
`ifdef DEV_TIMER_IRQ_EN
            im      <= 1'b0;
            irqPend <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (en) state <= LOAD;
                end
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (count != 32'd0) begin
                        count <= count - 32'd1;
                    end else begin
                        state <= INT;
`ifdef DEV_TIMER_IRQ_EN
                        irqPend <= 1'b1;
`endif
                    end
                end
                INT: begin
                    if (mode == 2'd1) begin
                        state <= LOAD;
`ifdef DEV_TIMER_IRQ_EN
                        irqPend <= 1'b0;
`endif
                    end else begin
                        state <= IDLE;
                        en    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (presetWrite) preset <= WD;

            if (ctrlWrite) begin
                en   <= WD[0];
                mode <= WD[2:1];
`ifdef DEV_TIMER_IRQ_EN
                im      <= WD[3];
                irqPend <= 1'b0;
`endif
                if (!WD[0]) begin
                    state <= IDLE;
                    count <= count;
                end
            end
        end
    end

    always_comb begin
        RD = 32'd0;
        case (Addr[3:2])
            2'd0:    RD = {28'd0, imBit, mode, en};
            2'd1:    RD = preset;
            2'd2:    RD = count;
            default: RD = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_dev_timer.sv
// Directed self-checking bench for dev_timer; IRQ expectations follow DEV_TIMER_IRQ_EN.
`ifndef DEV_ADDR_WD
`define DEV_ADDR_WD 32
`endif

module tb_dev_timer;

    logic                    clk;
    logic                    reset_n;
    logic [`DEV_ADDR_WD-1:0] Addr;
    logic                    WE;
    logic [31:0]             WD;
    logic [31:0]             RD;
    logic                    IRQ;

    int checks;
    int failures;

`ifdef DEV_TIMER_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif
    localparam logic [31:0] CTRL_MASK = IRQ_ON ? 32'hF : 32'h7;

    dev_timer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .Addr    (Addr),
        .WE      (WE),
        .WD      (WD),
        .RD      (RD),
        .IRQ     (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeReg(input logic [31:0] a, input logic [31:0] d);
        Addr = a[`DEV_ADDR_WD-1:0];
        WD   = d;
        WE   = 1'b1;
        tick();
        WE   = 1'b0;
    endtask

    task automatic readReg(input logic [31:0] a, output logic [31:0] v);
        Addr = a[`DEV_ADDR_WD-1:0];
        #1;
        v = RD;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        doReset();
        for (int i = 0; i < 4; i++) begin
            readReg(i * 4, v);
            checks++;
            if (v !== 32'd0) begin
                failures++;
                $display("[TB] FAIL reset_rd addr=%0h actual=%h expected=%h", i * 4, v, 32'd0);
            end
        end
        checks++;
        if (IRQ !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_irq actual=%b expected=0", IRQ);
        end
        // Reset must beat a simultaneous write.
        reset_n = 1'b0;
        writeReg(32'h4, 32'h1234);
        reset_n = 1'b1;
        readReg(32'h4, v);
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_over_we actual=%h expected=%h", v, 32'd0);
        end
        writeReg(32'hC, 32'hFFFF_FFFF);
        readReg(32'hC, v);
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reserved_rd actual=%h expected=%h", v, 32'd0);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        doReset();
        writeReg(32'h4, 32'd5);
        writeReg(32'h0, 32'h9);
        tick();
        tick();
        readReg(32'h8, v);
        checks++;
        if (v !== 32'd5) begin
            failures++;
            $display("[TB] FAIL oneshot_load actual=%0d expected=5", v);
        end
        for (int i = 4; i >= 0; i--) begin
            tick();
            readReg(32'h8, v);
            checks++;
            if (v !== i) begin
                failures++;
                $display("[TB] FAIL oneshot_count actual=%0d expected=%0d", v, i);
            end
            checks++;
            if (IRQ !== 1'b0) begin
                failures++;
                $display("[TB] FAIL oneshot_irq_early actual=%b expected=0", IRQ);
            end
        end
        tick();
        checks++;
        if (IRQ !== IRQ_ON) begin
            failures++;
            $display("[TB] FAIL oneshot_irq_rise actual=%b expected=%b", IRQ, IRQ_ON);
        end
        readReg(32'h8, v);
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("[TB] FAIL oneshot_no_wrap actual=%0d expected=0", v);
        end
        tick();
        readReg(32'h0, v);
        checks++;
        if (v !== (32'h8 & CTRL_MASK)) begin
            failures++;
            $display("[TB] FAIL oneshot_en_clear actual=%h expected=%h", v, 32'h8 & CTRL_MASK);
        end
        repeat (3) tick();
        checks++;
        if (IRQ !== IRQ_ON) begin
            failures++;
            $display("[TB] FAIL oneshot_irq_hold actual=%b expected=%b", IRQ, IRQ_ON);
        end
        writeReg(32'h0, 32'h0);
        checks++;
        if (IRQ !== 1'b0) begin
            failures++;
            $display("[TB] FAIL oneshot_irq_clear actual=%b expected=0", IRQ);
        end
    endtask

    task automatic test_autoreload();
        logic [31:0] v;
        logic [31:0] expCount;
        logic        expIrq;
        int          phase;
        doReset();
        writeReg(32'h4, 32'd2);
        writeReg(32'h0, 32'hB);
        for (int k = 1; k <= 16; k++) begin
            tick();
            readReg(32'h8, v);
            expIrq = ((k % 5) == 0) && IRQ_ON;
            checks++;
            if (IRQ !== expIrq) begin
                failures++;
                $display("[TB] FAIL reload_irq edge=%0d actual=%b expected=%b", k, IRQ, expIrq);
            end
            if (k >= 2) begin
                phase    = (k - 2) % 5;
                expCount = (phase == 0) ? 32'd2 : (phase == 1) ? 32'd1 : 32'd0;
                checks++;
                if (v !== expCount) begin
                    failures++;
                    $display("[TB] FAIL reload_count edge=%0d actual=%0d expected=%0d", k, v, expCount);
                end
            end
        end
        writeReg(32'h0, 32'h0);
    endtask

    task automatic test_stop_restart();
        logic [31:0] v;
        doReset();
        writeReg(32'h4, 32'd10);
        writeReg(32'h0, 32'h9);
        repeat (6) tick();
        readReg(32'h8, v);
        checks++;
        if (v !== 32'd6) begin
            failures++;
            $display("[TB] FAIL stop_pre actual=%0d expected=6", v);
        end
        writeReg(32'h0, 32'h8);
        repeat (12) tick();
        readReg(32'h8, v);
        checks++;
        if (v !== 32'd6) begin
            failures++;
            $display("[TB] FAIL stop_frozen actual=%0d expected=6", v);
        end
        checks++;
        if (IRQ !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stop_irq actual=%b expected=0", IRQ);
        end
        writeReg(32'h0, 32'h9);
        tick();
        tick();
        readReg(32'h8, v);
        checks++;
        if (v !== 32'd10) begin
            failures++;
            $display("[TB] FAIL restart_load actual=%0d expected=10", v);
        end
        tick();
        readReg(32'h8, v);
        checks++;
        if (v !== 32'd9) begin
            failures++;
            $display("[TB] FAIL restart_dec actual=%0d expected=9", v);
        end
        writeReg(32'h0, 32'h0);
    endtask

    task automatic test_preset_change();
        logic [31:0] v;
        doReset();
        writeReg(32'h4, 32'd4);
        writeReg(32'h0, 32'hB);
        repeat (3) tick();
        writeReg(32'h4, 32'd1);
        readReg(32'h8, v);
        checks++;
        if (v !== 32'd2) begin
            failures++;
            $display("[TB] FAIL preset_cur_count actual=%0d expected=2", v);
        end
        repeat (3) tick();
        checks++;
        if (IRQ !== IRQ_ON) begin
            failures++;
            $display("[TB] FAIL preset_irq1 actual=%b expected=%b", IRQ, IRQ_ON);
        end
        tick();
        tick();
        readReg(32'h8, v);
        checks++;
        if (v !== 32'd1) begin
            failures++;
            $display("[TB] FAIL preset_reload actual=%0d expected=1", v);
        end
        tick();
        checks++;
        if (IRQ !== 1'b0) begin
            failures++;
            $display("[TB] FAIL preset_irq_early actual=%b expected=0", IRQ);
        end
        tick();
        checks++;
        if (IRQ !== IRQ_ON) begin
            failures++;
            $display("[TB] FAIL preset_irq2 actual=%b expected=%b", IRQ, IRQ_ON);
        end
        writeReg(32'h0, 32'h0);
    endtask

    task automatic test_zero_preset();
        doReset();
        writeReg(32'h4, 32'd0);
        writeReg(32'h0, 32'h9);
        tick();
        tick();
        checks++;
        if (IRQ !== 1'b0) begin
            failures++;
            $display("[TB] FAIL zero_irq_early actual=%b expected=0", IRQ);
        end
        tick();
        checks++;
        if (IRQ !== IRQ_ON) begin
            failures++;
            $display("[TB] FAIL zero_irq actual=%b expected=%b", IRQ, IRQ_ON);
        end
        // A CTRL write on the edge that would raise irq_pend wins.
        doReset();
        writeReg(32'h0, 32'h9);
        tick();
        tick();
        writeReg(32'h0, 32'h9);
        checks++;
        if (IRQ !== 1'b0) begin
            failures++;
            $display("[TB] FAIL write_wins_irq actual=%b expected=0", IRQ);
        end
        writeReg(32'h0, 32'h0);
    endtask

    task automatic test_reset_midcount();
        logic [31:0] v;
        doReset();
        writeReg(32'h4, 32'd5);
        writeReg(32'h0, 32'h9);
        repeat (5) tick();
        readReg(32'h8, v);
        checks++;
        if (v !== 32'd2) begin
            failures++;
            $display("[TB] FAIL midreset_pre actual=%0d expected=2", v);
        end
        doReset();
        repeat (8) begin
            tick();
            checks++;
            if (IRQ !== 1'b0) begin
                failures++;
                $display("[TB] FAIL midreset_irq actual=%b expected=0", IRQ);
            end
        end
        for (int i = 0; i < 3; i++) begin
            readReg(i * 4, v);
            checks++;
            if (v !== 32'd0) begin
                failures++;
                $display("[TB] FAIL midreset_rd addr=%0h actual=%h expected=0", i * 4, v);
            end
        end
    endtask

    task automatic test_ctrl_mask();
        logic [31:0] v;
        doReset();
        writeReg(32'h0, 32'hFFFF_FFFF);
        readReg(32'h0, v);
        checks++;
        if (v !== CTRL_MASK) begin
            failures++;
            $display("[TB] FAIL ctrl_readback actual=%h expected=%h", v, CTRL_MASK);
        end
        writeReg(32'h0, 32'h0);
        readReg(32'h0, v);
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("[TB] FAIL ctrl_clear actual=%h expected=0", v);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        Addr     = '0;
        WE       = 1'b0;
        WD       = 32'd0;
        $display("[TB] starting dev_timer bench, irq feature=%0d", IRQ_ON);
        test_reset();
        test_oneshot();
        test_autoreload();
        test_stop_restart();
        test_preset_change();
        test_zero_preset();
        test_reset_midcount();
        test_ctrl_mask();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dev_timer.md
DEV_TIMER -- requirements
Module: dev_timer

Interface
REQ-001 The block SHALL have no parameters; word-address width SHALL come from the global macro `DEV_ADDR_WD.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, the reset; it SHALL be synchronous and active-low.
REQ-004 The block SHALL have port Addr, input, `DEV_ADDR_WD, the device-local byte address from the bridge; only Addr[3:2] SHALL be decoded.
REQ-005 The block SHALL have port WE, input, 1, the write strobe for the current cycle.
REQ-006 The block SHALL have port WD, input, 32, the write data (bridge DevWD).
REQ-007 The block SHALL have port RD, output, 32, the read data returned to the bridge's DevRD slot.
REQ-008 The block SHALL have port IRQ, output, 1, the level interrupt request.

Function
REQ-009 The register map SHALL be: Addr[3:2]=0 CTRL (R/W), 1 PRESET (R/W), 2 COUNT (read-only), 3 reserved (reads 0, writes ignored).
REQ-010 CTRL SHALL use bit0 EN, bits2:1 MODE, bit3 IM; bits31:4 SHALL read 0.
REQ-011 RD SHALL be combinational from Addr with zero-cycle latency; writes SHALL take effect at the clk edge where WE=1.
REQ-012 The FSM SHALL have states IDLE, LOAD, CNT and INT.
REQ-013 IDLE: with EN=1 the FSM SHALL go to LOAD on the next edge; otherwise it SHALL stay and COUNT SHALL hold.
REQ-014 LOAD: on the next edge COUNT SHALL be set to PRESET and the FSM SHALL go to CNT.
REQ-015 CNT: if COUNT!=0, COUNT SHALL decrement by 1; if COUNT==0, the FSM SHALL go to INT and set irq_pend.
REQ-016 INT with MODE=1 (auto-reload): the FSM SHALL go to LOAD on the next edge, clearing irq_pend (one-cycle pulse).
REQ-017 INT with MODE=0, 2 or 3 (one-shot): the FSM SHALL go to IDLE on the next edge, clear EN and keep irq_pend until the next CTRL write.
REQ-018 IRQ SHALL equal irq_pend AND IM.
REQ-019 A CTRL write with EN=0 in any state SHALL send the FSM to IDLE on that edge, with COUNT frozen.
REQ-020 Any CTRL write SHALL clear irq_pend.
REQ-021 A CTRL write in the same cycle as an internal EN clear or irq_pend set SHALL win.
REQ-022 A PRESET write during CNT SHALL NOT affect the current count; it SHALL apply only at the next LOAD.
REQ-023 PRESET=0 SHALL be legal: the FSM goes LOAD->CNT->INT, with IRQ 3 edges after the enabling write.
REQ-024 COUNT SHALL never wrap below 0.
REQ-025 For PRESET=N, IRQ SHALL rise N+3 edges after the enabling write; the MODE=1 period SHALL be N+3 cycles.

Reset
REQ-026 At a clk edge with reset_n=0: CTRL=0, PRESET=0, COUNT=0, irq_pend=0, FSM=IDLE; reset SHALL take priority over WE.
REQ-027 During and right after reset, IRQ SHALL be 0 and RD SHALL reflect the zeroed registers.
REQ-028 Reset asserted mid-count SHALL abort the count with no IRQ pulse.

Configuration
REQ-029 The block SHALL use macro DEV_TIMER_IRQ_EN.
REQ-030 With DEV_TIMER_IRQ_EN defined, irq_pend, IM and IRQ SHALL behave per REQ-015 to REQ-020.
REQ-031 Without DEV_TIMER_IRQ_EN, IRQ SHALL be tied 0, CTRL bit3 SHALL read 0 and ignore writes, and the FSM and COUNT SHALL be unchanged.

Verification
REQ-032 Reset then read all addresses -> RD=0 for Addr 0x0, 0x4, 0x8 and 0xC; IRQ=0.
REQ-033 Write PRESET=5, then CTRL=0x9 (EN, MODE0, IM) -> COUNT reads 5,4,3,2,1,0; IRQ high 8 edges after the CTRL write; EN reads 0; IRQ stays high until CTRL is written with 0x0.
REQ-034 PRESET=2, CTRL=0xB (MODE1, IM) -> IRQ one-cycle pulses every 5 cycles; COUNT reloads to 2 each period.
REQ-035 PRESET=10, enable, write CTRL=0x8 at COUNT=6 -> COUNT frozen at 6, no IRQ; rewriting 0x9 restarts from PRESET=10.
REQ-036 PRESET=4 counting; write PRESET=1 at COUNT=3 -> current period ends normally; with MODE1 the next period uses 1.
REQ-037 Pulse reset_n low at COUNT=2 -> all registers 0, no IRQ; rebuilt without DEV_TIMER_IRQ_EN -> IRQ constantly 0 and CTRL write 0xF reads back 0x7.
